dac_spi_slave: RTL and testbench

DAC_SPI_SLAVE -- requirements
Module: dac_spi_slave

---
 rtl/dac_spi_slave.sv | 224 ++++++++++++++++++++++
 tb/tb_dac_spi_slave.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_slave.sv
// dac_spi_slave
//   SPI slave front end for a four-channel 12-bit DAC. Frames are 32 bits,
//   MSB first: [31:24] ignored, [23:20] command, [19:16] address,
//   [15:4] data, [3:0] ignored. Every SPI input is resynchronised into the
//   CLK50MHZ domain; a frame executes one cycle after the CS rise is seen.
//   The previous frame (valid or not) is echoed back on DAC_OUT during the
//   next frame.
//
// Ports
//   CLK50MHZ            system clock, all state on its rising edge
//   RST                 asynchronous reset, active low
//   SPI_SCK             serial clock from the master (<= CLK50MHZ/4)
//   DAC_CS              frame select, active low
//   dac_in              serial data in, MSB first
//   DAC_CLR             clear of all input/DAC registers, active low
//   DAC_OUT             serial echo of the previous frame
//   dac_a..dac_d        DAC output registers, channels A..D
//   pwrdn               power-down flags, bit0 = A .. bit3 = D
//   frame_done          one-cycle pulse when a 32-bit frame executes
//   frame_err           one-cycle pulse when a frame ends with a count != 32
module dac_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK50MHZ,
  input  logic        RST,
  input  logic        SPI_SCK,
  input  logic        DAC_CS,
  input  logic        dac_in,
  input  logic        DAC_CLR,
  output logic        DAC_OUT,
  output logic [11:0] dac_a,
  output logic [11:0] dac_b,
  output logic [11:0] dac_c,
  output logic [11:0] dac_d,
  output logic [3:0]  pwrdn,
  output logic        frame_done,
  output logic        frame_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EXEC  = 2'd2
  } state_t;

  // Channel select decode: 0..3 pick one channel, 4'hF picks all, the rest none.
  function automatic logic [3:0] sel_decode(input logic [3:0] addr);
    logic [3:0] sel;
    sel = 4'b0000;
    if (addr == 4'hF)      sel = 4'b1111;
    else if (addr < 4'd4)  sel = 4'b0001 << addr[1:0];
    return sel;
  endfunction

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, din_sync, clr_sync;
  logic                   sck_prev, cs_prev;
  logic                   sck_s, cs_s, din_s, clr_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;

  state_t      state, state_nxt;
  logic        shift_in_en, shift_out_en;
  logic [31:0] shift_reg, out_shift, echo;
  logic [5:0]  bit_cnt;

  logic [11:0] in_reg  [4];
  logic [11:0] dac_reg [4];
  logic [3:0]  cmd, addr, sel;
  logic [11:0] data;

  // ---- input synchronisers and edge detect ----
  // The CS chain resets low so that a CS already low when RST releases is
  // never seen as a fall: a frame interrupted by reset is not picked up.
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      sck_sync <= '0;
      cs_sync  <= '0;
      din_sync <= '0;
      clr_sync <= '1;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], SPI_SCK};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], DAC_CS};
      din_sync <= {din_sync[SYNC_STAGES-2:0], dac_in};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], DAC_CLR};
      sck_prev <= sck_sync[SYNC_STAGES-1];
      cs_prev  <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign din_s    = din_sync[SYNC_STAGES-1];
  assign clr_s    = clr_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  assign cs_fall  = ~cs_s & cs_prev;

  // ---- frame state machine ----
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = EXEC;
      EXEC:    state_nxt = cs_fall ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // In the cycle the CS rise is detected the FSM is still in SHIFT, so the
  // synchronised CS gates shifting and the echo output.
  always_comb begin
    DAC_OUT      = 1'b0;
    shift_in_en  = 1'b0;
    shift_out_en = 1'b0;
    frame_done   = 1'b0;
    frame_err    = 1'b0;
    case (state)
      SHIFT: begin
        if (!cs_s) begin
          DAC_OUT      = out_shift[31];
          shift_in_en  = sck_rise;
          shift_out_en = sck_fall;
        end
      end
      EXEC: begin
        frame_done = (bit_cnt == 6'd32);
        frame_err  = (bit_cnt != 6'd32);
      end
      default: ;
    endcase
  end

  // ---- serial shifters and echo ----
  // A CS fall in EXEC means the echo register is being written this very
  // cycle, so the output shifter takes the just-completed frame directly.
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      shift_reg <= '0;
      out_shift <= '0;
      echo      <= '0;
      bit_cnt   <= '0;
    end else begin
      if (cs_fall) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
        out_shift <= (state == EXEC) ? shift_reg : echo;
      end else begin
        if (shift_in_en) begin
          shift_reg <= {shift_reg[30:0], din_s};
          if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
        end
        if (shift_out_en) out_shift <= {out_shift[30:0], 1'b0};
      end
      if (state == EXEC) echo <= shift_reg;
    end
  end

  // ---- command execution ----
  assign cmd  = shift_reg[23:20];
  assign addr = shift_reg[19:16];
  assign data = shift_reg[15:4];
  assign sel  = sel_decode(addr);

  // DAC_CLR is applied after the command so it overrides any write in the
  // same cycle; pwrdn is outside its reach.
  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 4; i++) begin
        in_reg[i]  <= '0;
        dac_reg[i] <= '0;
      end
      pwrdn <= 4'b0000;
    end else begin
      if (frame_done) begin
        case (cmd)
          4'h0: for (int i = 0; i < 4; i++)
                  if (sel[i]) begin
                    in_reg[i] <= data;
                    pwrdn[i]  <= 1'b0;
                  end
          4'h1: for (int i = 0; i < 4; i++)
                  if (sel[i]) begin
                    dac_reg[i] <= in_reg[i];
                    pwrdn[i]   <= 1'b0;
                  end
          4'h2: begin
            for (int i = 0; i < 4; i++) begin
              if (sel[i]) in_reg[i] <= data;
              dac_reg[i] <= sel[i] ? data : in_reg[i];
            end
            pwrdn <= 4'b0000;
          end
          4'h3: for (int i = 0; i < 4; i++)
                  if (sel[i]) begin
                    in_reg[i]  <= data;
                    dac_reg[i] <= data;
                    pwrdn[i]   <= 1'b0;
                  end
          4'h4: pwrdn <= pwrdn | sel;
          default: ;
        endcase
      end
      if (!clr_s) begin
        for (int i = 0; i < 4; i++) begin
          in_reg[i]  <= '0;
          dac_reg[i] <= '0;
        end
      end
    end
  end

  assign dac_a = dac_reg[0];
  assign dac_b = dac_reg[1];
  assign dac_c = dac_reg[2];
  assign dac_d = dac_reg[3];

endmodule

// File: tb/tb_dac_spi_slave.sv
// Directed bench for dac_spi_slave: a vector table of single frames with
// hand-computed register state, followed by hand-written sequences for
// DAC_CLR, back-to-back frames (CS fall during execute) and reset mid-frame.
module tb_dac_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n, sck, cs, din, clr;
  logic        dac_out;
  logic [11:0] dac_a, dac_b, dac_c, dac_d;
  logic [3:0]  pwrdn;
  logic        frame_done, frame_err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always #10 clk = ~clk;

  dac_spi_slave #(.SYNC_STAGES(2)) dut (
    .CLK50MHZ  (clk),
    .RST       (rst_n),
    .SPI_SCK   (sck),
    .DAC_CS    (cs),
    .dac_in    (din),
    .DAC_CLR   (clr),
    .DAC_OUT   (dac_out),
    .dac_a     (dac_a),
    .dac_b     (dac_b),
    .dac_c     (dac_c),
    .dac_d     (dac_d),
    .pwrdn     (pwrdn),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  always @(negedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
    if (frame_err)  err_cnt  <= err_cnt + 1;
  end

  typedef struct {
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [11:0] data;
    int          nbits;
    logic [47:0] dacs;   // {a, b, c, d}
    logic [3:0]  pw;
    logic        done;   // 1: frame_done expected, 0: frame_err expected
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SPI bit: data set while SCK low, DAC_OUT sampled just before the rise.
  task automatic spi_bit(input logic b, inout logic [31:0] cap, input logic keep);
    din = b;
    wait_clk(4);
    if (keep) cap = {cap[30:0], dac_out};
    sck = 1'b1;
    wait_clk(4);
    sck = 1'b0;
  endtask

  // Frames longer than 32 bits send leading zeros, then the 32-bit word.
  // Frames shorter than 32 bits send the top nbits of the word.
  task automatic do_frame(input logic [31:0] w, input int nbits, input int gap,
                          output logic [31:0] cap);
    logic [31:0] c;
    c  = '0;
    cs = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      logic b;
      if (nbits > 32) b = (i < nbits - 32) ? 1'b0 : w[nbits-1-i];
      else            b = w[31-i];
      spi_bit(b, c, i < 32);
    end
    wait_clk(4);
    cs = 1'b1;
    wait_clk(gap);
    cap = c;
  endtask

  function automatic logic [31:0] mk(input logic [3:0] cmd, input logic [3:0] addr,
                                     input logic [11:0] data);
    return {8'hA5, cmd, addr, data, 4'h6};
  endfunction

  initial begin
    logic [31:0] w, wa, wb, cap, cap_b, exp_echo;
    int d0, e0;

    vecs[0]  = '{4'h3, 4'h0, 12'hABC, 32, 48'hABC_000_000_000, 4'b0000, 1'b1};
    vecs[1]  = '{4'h0, 4'h1, 12'h123, 32, 48'hABC_000_000_000, 4'b0000, 1'b1};
    vecs[2]  = '{4'h1, 4'h1, 12'h000, 32, 48'hABC_123_000_000, 4'b0000, 1'b1};
    vecs[3]  = '{4'h3, 4'hF, 12'hFFF, 32, 48'hFFF_FFF_FFF_FFF, 4'b0000, 1'b1};
    vecs[4]  = '{4'h4, 4'h2, 12'h000, 32, 48'hFFF_FFF_FFF_FFF, 4'b0100, 1'b1};
    vecs[5]  = '{4'h3, 4'h0, 12'h555, 24, 48'hFFF_FFF_FFF_FFF, 4'b0100, 1'b0};
    vecs[6]  = '{4'h2, 4'h3, 12'h777, 32, 48'hFFF_FFF_FFF_777, 4'b0000, 1'b1};
    vecs[7]  = '{4'h0, 4'h7, 12'h111, 32, 48'hFFF_FFF_FFF_777, 4'b0000, 1'b1};
    vecs[8]  = '{4'h0, 4'h0, 12'h222, 32, 48'hFFF_FFF_FFF_777, 4'b0000, 1'b1};
    vecs[9]  = '{4'h4, 4'hF, 12'h000, 32, 48'hFFF_FFF_FFF_777, 4'b1111, 1'b1};
    vecs[10] = '{4'h1, 4'hF, 12'h000, 32, 48'h222_FFF_FFF_777, 4'b0000, 1'b1};
    vecs[11] = '{4'hF, 4'h0, 12'h000, 32, 48'h222_FFF_FFF_777, 4'b0000, 1'b1};
    vecs[12] = '{4'h3, 4'hF, 12'h000, 66, 48'h222_FFF_FFF_777, 4'b0000, 1'b0};
    vecs[13] = '{4'h5, 4'h0, 12'h000, 32, 48'h222_FFF_FFF_777, 4'b0000, 1'b1};
    vecs[14] = '{4'h4, 4'h3, 12'h000, 32, 48'h222_FFF_FFF_777, 4'b1000, 1'b1};

    rst_n = 1'b0; cs = 1'b1; sck = 1'b0; din = 1'b0; clr = 1'b1;
    wait_clk(3);
    check("reset dacs",  {dac_a, dac_b, dac_c, dac_d}, 48'h0);
    check("reset pwrdn", pwrdn, 4'b0000);
    check("reset pulses/out", {frame_done, frame_err, dac_out}, 3'b000);
    rst_n = 1'b1;
    wait_clk(5);

    exp_echo = '0;
    for (int i = 0; i < 15; i++) begin
      w  = mk(vecs[i].cmd, vecs[i].addr, vecs[i].data);
      d0 = done_cnt;
      e0 = err_cnt;
      do_frame(w, vecs[i].nbits, 10, cap);
      check($sformatf("v%0d dacs", i), {dac_a, dac_b, dac_c, dac_d}, vecs[i].dacs);
      check($sformatf("v%0d pwrdn", i), pwrdn, vecs[i].pw);
      check($sformatf("v%0d done", i), done_cnt - d0, vecs[i].done ? 1 : 0);
      check($sformatf("v%0d err", i), err_cnt - e0, vecs[i].done ? 0 : 1);
      if (vecs[i].nbits >= 32) check($sformatf("v%0d echo", i), cap, exp_echo);
      exp_echo = (vecs[i].nbits >= 32) ? w : (w >> (32 - vecs[i].nbits));
    end

    // DAC_CLR pulse: registers cleared, pwrdn and echo untouched.
    clr = 1'b0;
    wait_clk(5);
    clr = 1'b1;
    wait_clk(6);
    check("clr dacs",  {dac_a, dac_b, dac_c, dac_d}, 48'h0);
    check("clr pwrdn", pwrdn, 4'b1000);
    w  = mk(4'h1, 4'hF, 12'h000);
    d0 = done_cnt;
    do_frame(w, 32, 10, cap);
    check("clr inputs cleared", {dac_a, dac_b, dac_c, dac_d}, 48'h0);
    check("clr update pwrdn", pwrdn, 4'b0000);
    check("clr echo kept", cap, exp_echo);
    check("clr done", done_cnt - d0, 1);
    exp_echo = w;

    // Back-to-back frames: CS high for one clock, so its fall lands in EXEC.
    wa = mk(4'h3, 4'h1, 12'h246);
    wb = mk(4'h4, 4'hF, 12'h000);
    d0 = done_cnt;
    e0 = err_cnt;
    do_frame(wa, 32, 1, cap);
    do_frame(wb, 32, 10, cap_b);
    check("b2b echo A", cap, exp_echo);
    check("b2b echo B", cap_b, wa);
    check("b2b dacs", {dac_a, dac_b, dac_c, dac_d}, 48'h000_246_000_000);
    check("b2b pwrdn", pwrdn, 4'b1111);
    check("b2b done", done_cnt - d0, 2);
    check("b2b err", err_cnt - e0, 0);

    // Reset after 16 SCK rises, CS still low.
    d0 = done_cnt;
    e0 = err_cnt;
    w  = mk(4'h3, 4'hF, 12'h999);
    cap = '0;
    cs = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 16; i++) spi_bit(w[31-i], cap, 1'b0);
    rst_n = 1'b0;
    wait_clk(2);
    check("midrst dacs", {dac_a, dac_b, dac_c, dac_d}, 48'h0);
    check("midrst pwrdn", pwrdn, 4'b0000);
    check("midrst pulses/out", {frame_done, frame_err, dac_out}, 3'b000);
    cs = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(10);
    check("midrst no pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    w  = mk(4'h3, 4'h0, 12'hABC);
    d0 = done_cnt;
    do_frame(w, 32, 10, cap);
    check("postrst dacs", {dac_a, dac_b, dac_c, dac_d}, 48'hABC_000_000_000);
    check("postrst done", done_cnt - d0, 1);
    check("postrst echo", cap, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
